// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-memory responder.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request fields carried from acceptance to the array access
    typedef struct packed {
        logic              we;
        logic              misalign;
        logic [WORD_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read.
// Contents are never reset; only the read register is.
module dmem_array
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Stores and suppressed accesses present zero read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (clr || (en && we)) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder with programmable wait states.
// Optional misaligned-access error response: define DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dmem_req_t         req_q, req_d, cur_c;
    logic [AW-1:0]     idx_q, idx_d, cur_idx_c;
    logic              ready_d, valid_d, err_d;
    logic              misalign_c, enter_resp_c, mem_en_c, mem_clr_c;
    logic              unused_addr_c;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign_c    = |req_addr[1:0];
    assign unused_addr_c = ^req_addr[WORD_W-1:AW+2];
`else
    assign misalign_c    = 1'b0;
    assign unused_addr_c = ^{req_addr[WORD_W-1:AW+2], req_addr[1:0]};
`endif

    // Zero-wait requests hit the array on the accepting edge, so use live inputs in IDLE
    always_comb begin
        if (state_q == IDLE) begin
            cur_c.we       = req_we;
            cur_c.misalign = misalign_c;
            cur_c.wdata    = req_wdata;
            cur_idx_c      = req_addr[AW+1:2];
        end else begin
            cur_c     = req_q;
            cur_idx_c = idx_q;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        idx_d        = idx_q;
        valid_d      = rsp_valid;
        err_d        = rsp_err;
        enter_resp_c = 1'b0;
        mem_en_c     = 1'b0;
        mem_clr_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_d = cur_c;
                    idx_d = cur_idx_c;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp_c) begin
            valid_d   = 1'b1;
            err_d     = cur_c.misalign;
            mem_en_c  = ~cur_c.misalign;
            mem_clr_c = cur_c.misalign;
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            idx_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            req_ready <= ready_d;
            rsp_valid <= valid_d;
            rsp_err   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en_c),
        .we    (cur_c.we),
        .clr   (mem_clr_c),
        .addr  (cur_idx_c),
        .wdata (cur_c.wdata),
        .rdata (rsp_rdata)
    );

endmodule
